// File: rtl/AU_dec_c.sv
// Decrementer with borrow-in/borrow-out: z = a - ci, co = ci & (a == 0).
// ARCH picks the implementation: 0 ripple borrow, 1 borrow lookahead, 2 behavioural subtract.
module AU_dec_c #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic [WIDTH-1:0] z,
    output logic             co
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "AU_dec_c: WIDTH must be >= 1");
    end
    if (ARCH < 0 || ARCH > 2) begin : g_bad_arch
        $fatal(1, "AU_dec_c: ARCH must be in 0..2");
    end

    if (ARCH == 0) begin : g_ripple
        logic [WIDTH:0] borrow;
        always_comb begin
            borrow[0] = ci;
            for (int i = 0; i < WIDTH; i++) begin
                z[i]          = a[i] ^ borrow[i];
                borrow[i + 1] = borrow[i] & ~a[i];
            end
        end
        assign co = borrow[WIDTH];
    end else if (ARCH == 1) begin : g_lookahead
        // Each bit borrows directly when every lower bit is zero.
        logic [WIDTH-1:0] mask;
        always_comb begin
            mask = '0;
            z    = '0;
            for (int i = 0; i < WIDTH; i++) begin
                mask = (WIDTH'(1) << i) - WIDTH'(1);
                z[i] = a[i] ^ (ci & ~|(a & mask));
            end
        end
        assign co = ci & ~|a;
    end else begin : g_behav
        logic [WIDTH:0] diff;
        assign diff = {1'b0, a} - {{WIDTH{1'b0}}, ci};
        assign z    = diff[WIDTH-1:0];
        assign co   = diff[WIDTH];
    end

endmodule

// File: rtl/au_dec_cnt.sv
// Loadable, cascadable down-counter around AU_dec_c with optional auto-reload,
// registered zero flag, one-cycle terminal-count pulse and combinational borrow-out.
module au_dec_cnt #(
    parameter int WIDTH  = 8,
    parameter int ARCH   = 0,
    parameter int RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             ci,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             co,
    output logic             tc
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "au_dec_cnt: WIDTH must be >= 1");
    end
    if (ARCH < 0 || ARCH > 2) begin : g_bad_arch
        $fatal(1, "au_dec_cnt: ARCH must be in 0..2");
    end
    if (RELOAD < 0 || RELOAD > 1) begin : g_bad_reload
        $fatal(1, "au_dec_cnt: RELOAD must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] Zero = '0;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             zero_q, zero_d;
    logic             tc_q, tc_d;

    logic             dec;
    logic [WIDTH-1:0] dec_z;
    logic             dec_co;

    assign dec = en & ci & ~ld & ~rst;

    AU_dec_c #(
        .WIDTH(WIDTH),
        .ARCH (ARCH)
    ) u_dec (
        .a (cnt_q),
        .ci(dec),
        .z (dec_z),
        .co(dec_co)
    );

    // dec_co already carries the dec gating through the decrementer's ci.
    assign co = dec_co;

    always_comb begin
        cnt_d = cnt_q;
        rld_d = rld_q;
        tc_d  = 1'b0;
        if (ld) begin
            cnt_d = ld_val;
            rld_d = ld_val;
        end else if (dec) begin
            if (dec_co) begin
                tc_d  = 1'b1;
                // On underflow dec_z is already all ones, i.e. the modular wrap.
                cnt_d = (RELOAD == 1) ? rld_q : dec_z;
            end else begin
                cnt_d = dec_z;
            end
        end
        zero_d = (cnt_d == Zero);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= Zero;
            rld_q  <= Zero;
            zero_q <= 1'b1;
            tc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rld_q  <= rld_d;
            zero_q <= zero_d;
            tc_q   <= tc_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = zero_q;
    assign tc   = tc_q;

endmodule

// File: doc/au_dec_cnt.md
Name: au_dec_cnt

Overview:
Loadable, cascadable down-counter built around the decrementer stage AU_dec_c (ci/co borrow form). It registers the decrementer output each enabled cycle. It also provides load, optional auto-reload, zero detect, a terminal-count pulse, and a borrow-out for chaining wider counters. It is the first sequential consumer of the decrementer in the arithmetic library.

Parameters:
WIDTH, 8, counter word length (>= 1)
ARCH, 0, architecture passed to the decrementer instance (0 to 2)
RELOAD, 0, 0 = modular wrap on underflow; 1 = reload from captured load value on underflow

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ld  input  1  load strobe
ld_val  input  WIDTH  load value; also captured into the reload register
en  input  1  count enable
ci  input  1  borrow-in (decrement request); from the previous stage co when cascaded
cnt  output  WIDTH  current count (registered)
zero  output  1  registered, cnt == 0
co  output  1  combinational borrow-out to the next stage
tc  output  1  registered one-cycle terminal-count pulse

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset, synchronous, active-high: cnt = 0, rld (internal reload register) = 0, zero = 1, tc = 0. co is forced 0 while rst = 1.
- Priority each cycle: rst > ld > decrement > hold.
- ld = 1: cnt <= ld_val; rld <= ld_val; zero <= (ld_val == 0); tc <= 0. Any en/ci in the same cycle is ignored, and co = 0.
- Decrement condition: dec = en & ci & ~ld & ~rst.
- dec = 1 and cnt != 0: cnt <= cnt - 1, taken from the AU_dec_c z output with its ci = 1.
- dec = 1 and cnt == 0 (underflow):
  - co = 1 combinationally in that cycle.
  - tc <= 1 for exactly one cycle.
  - RELOAD = 0: cnt <= all ones (2^WIDTH - 1).
  - RELOAD = 1: cnt <= rld. If rld == 0, cnt stays 0 and underflows again on every decrement.
- dec = 0: cnt holds and tc <= 0.
- co = dec & (cnt == 0), equal to the decrementer carry-out gated by dec. It has no register, so a cascaded chain borrows in the same cycle.
- zero is registered from the next-state value, so it is always consistent with cnt.
- Latency: cnt reflects ld/dec one cycle after the edge. tc asserts on the cycle after the underflow edge, aligned with the reloaded/wrapped cnt.
- rst asserted mid-count discards the count and rld. The first ld after reset is required before RELOAD = 1 yields a nonzero period.
- WIDTH = 1 is legal: the counter toggles 1 -> 0 -> 1 (RELOAD = 0).
- Parameter check at elaboration: WIDTH < 1, ARCH outside 0..2, or RELOAD outside 0..1 print an error and call $finish.

Decomposition:
- No shared package is needed. The ARCH encoding stays as defined for AU_dec_c; the zero constant is local.
- One sub-module: AU_dec_c, instantiated with a = cnt, ci = dec, and its z/co used as described above.
- Reload mux, registers and tc/zero logic stay in au_dec_cnt.

Test Plan:
1. Reset: rst = 1 for 2 cycles with ld = en = ci = 1 -> cnt = 0, zero = 1, tc = 0, co = 0 throughout.
2. WIDTH = 8, RELOAD = 0: ld ld_val = 5, then en = ci = 1 for 7 cycles -> cnt = 4, 3, 2, 1, 0, 255, 254. co = 1 only in the cycle where cnt = 0. tc = 1 only in the cycle where cnt = 255.
3. RELOAD = 1: ld 3, then en = ci = 1 for 8 cycles -> cnt = 2, 1, 0, 3, 2, 1, 0, 3. tc pulses when cnt returns to 3.
4. Load collision and hold: cnt = 9, then ld = 1, ld_val = 0x40, en = ci = 1 -> cnt = 0x40 with no decrement and co = 0. Then ci = 0 with en = 1 for 3 cycles -> cnt stays 0x40 and tc = 0.
5. Cascade two WIDTH = 4 instances (low co -> high ci, both en = 1, low ci = 1): load high = 1, low = 0 (value 0x10); one cycle -> {high, low} = 0x0F. Further cycles continue 0x0E, and so on.
6. Reset mid-operation: RELOAD = 1, ld 7, count to 4, then rst for 1 cycle -> cnt = 0. Then decrements -> cnt stays 0, and co/tc fire on every dec because rld was cleared.
